// File: rtl/io_uart_mmio.sv
// io_uart_mmio - memory-mapped I/O slave for the MIPS150 pipeline.
// Provides a UART transmitter/receiver and free-running cycle and
// instruction counters. Read data is registered so it lines up with
// DMEM's synchronous read in the M-stage writeback mux.
//
// Ports:
//   clk          core clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   addr         X-stage byte address; only addr[7:2] is decoded
//   wdata        store data; only wdata[7:0] is used
//   store_mask   IO byte write enables; any nonzero value is a write
//   load_en      X-stage IO load strobe
//   instr_valid  one instruction retired this cycle
//   rdata        registered read data, valid the cycle after load_en
//   serial_in    UART RX pin (asynchronous)
//   serial_out   UART TX pin
//
// Register map (addr[7:0]):
//   0x00 R tx_ready | 0x04 R {overrun, frame_err, rx_valid}, sticky bits
//   clear on read | 0x08 R rx byte, read pops | 0x0C W tx byte
//   0x10 R cycle counter | 0x14 R instruction counter | 0x18 W clear counters
//
// Build option: define UART_RX_FIFO_EN to replace the single RX holding
// register with a 4-entry FIFO.
module io_uart_mmio #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  store_mask,
  input  logic        load_en,
  input  logic        instr_valid,
  output logic [31:0] rdata,
  input  logic        serial_in,
  output logic        serial_out
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  localparam logic [5:0] W_TXSTAT = 6'd0;
  localparam logic [5:0] W_RXSTAT = 6'd1;
  localparam logic [5:0] W_RXDATA = 6'd2;
  localparam logic [5:0] W_TXDATA = 6'd3;
  localparam logic [5:0] W_CYCLE  = 6'd4;
  localparam logic [5:0] W_INSTR  = 6'd5;
  localparam logic [5:0] W_CLEAR  = 6'd6;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartState_t;

  logic [5:0] word;
  logic       wrEn;
  logic       unusedBits;

  assign word       = addr[7:2];
  assign wrEn       = |store_mask;
  assign unusedBits = ^{addr[31:8], addr[1:0], wdata[31:8]};

  // ---------------- TX ----------------
  uartState_t    txState;
  logic [CW-1:0] txCnt;
  logic [2:0]    txBit;
  logic [7:0]    txShift;
  logic          txReady;

  assign txReady = (txState == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txState    <= IDLE;
      txCnt      <= '0;
      txBit      <= '0;
      txShift    <= '0;
      serial_out <= 1'b1;
    end else begin
      case (txState)
        IDLE: begin
          if (wrEn && word == W_TXDATA) begin
            txShift    <= wdata[7:0];
            txCnt      <= '0;
            serial_out <= 1'b0;
            txState    <= START;
          end
        end
        START: begin
          if (txCnt == BIT_LAST) begin
            txCnt      <= '0;
            txBit      <= '0;
            serial_out <= txShift[0];
            txShift    <= txShift >> 1;
            txState    <= DATA;
          end else begin
            txCnt <= txCnt + 1'b1;
          end
        end
        DATA: begin
          if (txCnt == BIT_LAST) begin
            txCnt <= '0;
            if (txBit == 3'd7) begin
              serial_out <= 1'b1;
              txState    <= STOP;
            end else begin
              serial_out <= txShift[0];
              txShift    <= txShift >> 1;
              txBit      <= txBit + 1'b1;
            end
          end else begin
            txCnt <= txCnt + 1'b1;
          end
        end
        STOP: begin
          if (txCnt == BIT_LAST) begin
            txCnt   <= '0;
            txState <= IDLE;
          end else begin
            txCnt <= txCnt + 1'b1;
          end
        end
        default: txState <= IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  uartState_t    rxState;
  logic [CW-1:0] rxCnt;
  logic [2:0]    rxBit;
  logic [7:0]    rxShift;
  logic          rxMeta;
  logic          rxSync;
  logic          rxDeliver;
  logic          rxFrameErrSet;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxMeta        <= 1'b1;
      rxSync        <= 1'b1;
      rxState       <= IDLE;
      rxCnt         <= '0;
      rxBit         <= '0;
      rxShift       <= '0;
      rxDeliver     <= 1'b0;
      rxFrameErrSet <= 1'b0;
    end else begin
      rxMeta        <= serial_in;
      rxSync        <= rxMeta;
      rxDeliver     <= 1'b0;
      rxFrameErrSet <= 1'b0;
      case (rxState)
        IDLE: begin
          if (!rxSync) begin
            rxCnt   <= '0;
            rxState <= START;
          end
        end
        START: begin
          // Half a bit in: a line back at 1 means the edge was a glitch.
          if (rxCnt == HALF_LAST) begin
            rxCnt   <= '0;
            rxBit   <= '0;
            rxState <= rxSync ? IDLE : DATA;
          end else begin
            rxCnt <= rxCnt + 1'b1;
          end
        end
        DATA: begin
          if (rxCnt == BIT_LAST) begin
            rxCnt   <= '0;
            rxShift <= {rxSync, rxShift[7:1]};
            if (rxBit == 3'd7) rxState <= STOP;
            else               rxBit   <= rxBit + 1'b1;
          end else begin
            rxCnt <= rxCnt + 1'b1;
          end
        end
        STOP: begin
          if (rxCnt == BIT_LAST) begin
            rxCnt <= '0;
            if (rxSync) rxDeliver     <= 1'b1;
            else        rxFrameErrSet <= 1'b1;
            rxState <= IDLE;
          end else begin
            rxCnt <= rxCnt + 1'b1;
          end
        end
        default: rxState <= IDLE;
      endcase
    end
  end

  // ---------------- RX storage ----------------
  logic       rxValid;
  logic [7:0] rxHead;
  logic       rxPop;
  logic       overrunSet;

  assign rxPop = load_en && (word == W_RXDATA) && rxValid;

`ifdef UART_RX_FIFO_EN
  logic [7:0] rxFifo [4];
  logic [1:0] rxHeadPtr;
  logic [2:0] rxCount;
  logic       rxFull;
  logic       rxPush;

  assign rxFull     = (rxCount == 3'd4);
  assign rxPush     = rxDeliver && (!rxFull || rxPop);
  assign overrunSet = rxDeliver && rxFull && !rxPop;
  assign rxValid    = (rxCount != 3'd0);
  assign rxHead     = rxFifo[rxHeadPtr];

  // When full with a simultaneous pop, head+count wraps onto the slot
  // being vacated, which is exactly where the new byte belongs.
  always_ff @(posedge clk) begin
    if (rxPush) rxFifo[rxHeadPtr + rxCount[1:0]] <= rxShift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxHeadPtr <= '0;
      rxCount   <= '0;
    end else begin
      if (rxPop) rxHeadPtr <= rxHeadPtr + 1'b1;
      case ({rxPush, rxPop})
        2'b10:   rxCount <= rxCount + 1'b1;
        2'b01:   rxCount <= rxCount - 1'b1;
        default: rxCount <= rxCount;
      endcase
    end
  end
`else
  logic [7:0] rxByte;
  logic       rxValidReg;

  assign overrunSet = rxDeliver && rxValidReg && !rxPop;
  assign rxValid    = rxValidReg;
  assign rxHead     = rxByte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxByte     <= '0;
      rxValidReg <= 1'b0;
    end else if (rxDeliver && (!rxValidReg || rxPop)) begin
      rxByte     <= rxShift;
      rxValidReg <= 1'b1;
    end else if (rxPop) begin
      rxValidReg <= 1'b0;
    end
  end
`endif

  // Sticky status: a new error event on the clearing edge is kept.
  logic frameErr;
  logic overrun;
  logic stickyClr;

  assign stickyClr = load_en && (word == W_RXSTAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      frameErr <= (frameErr && !stickyClr) || rxFrameErrSet;
      overrun  <= (overrun && !stickyClr) || overrunSet;
    end
  end

  // ---------------- Counters ----------------
  logic [31:0] cycleCnt;
  logic [31:0] instrCnt;
  logic        cntClr;

  assign cntClr = wrEn && (word == W_CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycleCnt <= '0;
      instrCnt <= '0;
    end else if (cntClr) begin
      cycleCnt <= '0;
      instrCnt <= '0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (instr_valid) instrCnt <= instrCnt + 32'd1;
    end
  end

  // ---------------- Read path ----------------
  logic [31:0] rdNext;

  always_comb begin
    rdNext = '0;
    case (word)
      W_TXSTAT: rdNext[0]   = txReady;
      W_RXSTAT: rdNext[2:0] = {overrun, frameErr, rxValid};
      W_RXDATA: rdNext[7:0] = rxValid ? rxHead : 8'h00;
      W_CYCLE:  rdNext      = cycleCnt;
      W_INSTR:  rdNext      = instrCnt;
      default:  rdNext      = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         rdata <= '0;
    else if (load_en) rdata <= rdNext;
  end

endmodule

// File: tb/tb_io_uart_mmio.sv
// Testbench for io_uart_mmio with a small baud divider (10 clocks per bit).
// A behavioural model tracks the register file, a byte queue for received
// data, and the transmit frame as elapsed time since the accepted write.
module tb_io_uart_mmio;
  localparam int CLK_FREQ  = 1000;
  localparam int BAUD_RATE = 100;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_FIFO_EN
  localparam int RXD = 4;
`else
  localparam int RXD = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  store_mask;
  logic        load_en;
  logic        instr_valid;
  logic [31:0] rdata;
  logic        serial_in;
  logic        serial_out;

  io_uart_mmio #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .store_mask(store_mask), .load_en(load_en), .instr_valid(instr_valid),
    .rdata(rdata), .serial_in(serial_in), .serial_out(serial_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- model ----------------
  logic [31:0] mRdata;
  logic [31:0] mCyc;
  logic [31:0] mIns;
  bit          mTxBusy;
  int          mTxT;
  logic [7:0]  mTxByte;
  logic [7:0]  mRxQ[$];
  bit          mFerr;
  bit          mOvr;

  int         forceReq = 0, forceAck = 0;
  int         evReq = 0, evAck = 0;
  bit         evIsErr;
  logic [7:0] evByte;

  int          litReq = 0, litAck = 0;
  bit          litIsSerial;
  logic [31:0] litExp;
  string       litName;

  bit instrRand = 1'b1;
  bit instrFixed = 1'b0;

  function automatic logic [31:0] mRead(input logic [5:0] w);
    case (w)
      6'd0: return {31'b0, !mTxBusy};
      6'd1: return {29'b0, mOvr, mFerr, mRxQ.size() != 0};
      6'd2: return (mRxQ.size() != 0) ? {24'b0, mRxQ[0]} : 32'b0;
      6'd4: return mCyc;
      6'd5: return mIns;
      default: return 32'b0;
    endcase
  endfunction

  // Line level is a pure function of time since the accepted write:
  // one start bit, eight data bits LSB first, one stop bit, CPB clocks each.
  function automatic logic mSerial();
    int seg;
    if (!mTxBusy) return 1'b1;
    seg = mTxT / CPB;
    if (seg == 0) return 1'b0;
    if (seg <= 8) return mTxByte[seg-1];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic [5:0] w;
    bit wr, preBusy;
    if (!rst) begin
      mRdata = '0; mCyc = '0; mIns = '0;
      mTxBusy = 1'b0; mTxT = 0; mTxByte = '0;
      mRxQ.delete(); mFerr = 1'b0; mOvr = 1'b0;
    end else begin
      w  = addr[7:2];
      wr = |store_mask;
      if (forceReq != forceAck) begin mCyc = '1; forceAck = forceReq; end
      if (load_en) begin
        mRdata = mRead(w);
        if (w == 6'd2 && mRxQ.size() != 0) void'(mRxQ.pop_front());
        if (w == 6'd1) begin mFerr = 1'b0; mOvr = 1'b0; end
      end
      if (wr && w == 6'd6) begin
        mCyc = '0; mIns = '0;
      end else begin
        mCyc = mCyc + 1;
        if (instr_valid) mIns = mIns + 1;
      end
      preBusy = mTxBusy;
      if (mTxBusy) begin
        mTxT++;
        if (mTxT == 10 * CPB) mTxBusy = 1'b0;
      end
      if (wr && w == 6'd3 && !preBusy) begin
        mTxBusy = 1'b1; mTxT = 0; mTxByte = wdata[7:0];
      end
      if (evReq != evAck) begin
        evAck = evReq;
        if (evIsErr)                 mFerr = 1'b1;
        else if (mRxQ.size() < RXD)  mRxQ.push_back(evByte);
        else                         mOvr = 1'b1;
      end
    end
  end

  // ---------------- compare ----------------
  always @(negedge clk) begin
    logic [31:0] act;
    vectors++;
    if (rdata !== mRdata) begin
      miscompares++;
      $display("FAIL rdata: got %h expected %h at %0t", rdata, mRdata, $time);
    end
    vectors++;
    if (serial_out !== mSerial()) begin
      miscompares++;
      $display("FAIL serial_out: got %b expected %b at %0t", serial_out, mSerial(), $time);
    end
    if (litReq != litAck) begin
      litAck = litReq;
      act = litIsSerial ? {31'b0, serial_out} : rdata;
      vectors++;
      if (act !== litExp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h at %0t", litName, act, litExp, $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic postLit(input bit isSer, input logic [31:0] exp, input string name);
    litIsSerial = isSer; litExp = exp; litName = name; litReq++;
  endtask

  task automatic cyc(input logic [5:0] w, input logic [31:0] wd,
                     input logic [3:0] m, input logic ld);
    logic [31:0] r;
    @(negedge clk);
    r = $urandom();
    addr        = {r[31:8], w, r[1:0]};
    wdata       = wd;
    store_mask  = m;
    load_en     = ld;
    instr_valid = instrRand ? 1'($urandom_range(0, 1)) : instrFixed;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(6'd0, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic readExpect(input logic [5:0] w, input logic [31:0] exp, input string name);
    cyc(w, $urandom(), 4'd0, 1'b1);
    #1 postLit(1'b0, exp, name);
  endtask

  task automatic sendFrame(input logic [7:0] b, input bit badStop);
    logic [9:0] bits;
    bits = {!badStop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      #1 serial_in = bits[i];
      idle(CPB);
    end
    #1 serial_in = 1'b1;
    idle(CPB + 5);
    @(negedge clk);
    evIsErr = badStop; evByte = b; evReq++;
    load_en = 1'b0; store_mask = 4'd0;
    @(posedge clk);
  endtask

  task automatic glitch();
    #1 serial_in = 1'b0;
    idle(2);
    #1 serial_in = 1'b1;
    idle(2 * CPB);
  endtask

  bit patA5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b0; addr = '0; wdata = '0; store_mask = '0; load_en = 1'b0;
    instr_valid = 1'b0; serial_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 postLit(1'b0, 32'h0, "reset_rdata");
    readExpect(6'd0, 32'h1, "reset_tx_ready");
    readExpect(6'd1, 32'h0, "reset_rx_status");

    // TX frame 0xA5
    cyc(6'd3, 32'h0000_00A5, 4'b0001, 1'b0);
    for (int t = 1; t <= 10 * CPB + 2; t++) begin
      cyc(6'd0, 32'd0, 4'd0, t == 50);
      #1;
      if (t == 50) postLit(1'b0, 32'h0, "tx_ready_busy");
      else if (t % CPB == CPB / 2 && t / CPB < 10) postLit(1'b1, {31'b0, patA5[t / CPB]}, "tx_bit");
    end
    readExpect(6'd0, 32'h1, "tx_ready_after");

    // RX single frame
    sendFrame(8'h3C, 1'b0);
    readExpect(6'd1, 32'h1, "rx_valid");
    readExpect(6'd2, 32'h3C, "rx_byte");
    readExpect(6'd1, 32'h0, "rx_after_pop");

    // Two frames without popping
    sendFrame(8'h11, 1'b0);
    sendFrame(8'h22, 1'b0);
`ifdef UART_RX_FIFO_EN
    readExpect(6'd1, 32'h1, "fifo_status");
    readExpect(6'd2, 32'h11, "fifo_pop0");
    readExpect(6'd2, 32'h22, "fifo_pop1");
`else
    readExpect(6'd1, 32'h5, "overrun_status");
    readExpect(6'd2, 32'h11, "overrun_kept");
`endif
    readExpect(6'd2, 32'h0, "rx_empty_read");

    // Bad stop bit
    sendFrame(8'h55, 1'b1);
    readExpect(6'd1, 32'h2, "frame_err");
    readExpect(6'd1, 32'h0, "frame_err_clear");

    glitch();
    readExpect(6'd1, 32'h0, "glitch_ignored");

    // Counters
    instrRand = 1'b0; instrFixed = 1'b0;
    cyc(6'd6, $urandom(), 4'b1000, 1'b0);
    for (int i = 0; i < 100; i++) begin
      instrFixed = (i < 40);
      cyc(6'd0, 32'd0, 4'd0, 1'b0);
    end
    instrFixed = 1'b0;
    readExpect(6'd4, 32'd100, "cycle_cnt");
    readExpect(6'd5, 32'd40, "instr_cnt");
    @(negedge clk);
    force dut.cycleCnt = 32'hFFFF_FFFF;
    forceReq++;
    addr = {24'h0, 6'd4, 2'b00}; load_en = 1'b1; store_mask = 4'd0;
    #1 release dut.cycleCnt;
    @(posedge clk); #1 postLit(1'b0, 32'hFFFF_FFFF, "cycle_wrap_pre");
    readExpect(6'd4, 32'h0, "cycle_wrap");
    instrRand = 1'b1;

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      int unsigned r;
      logic [5:0] w;
      r = $urandom_range(0, 15);
      if (r <= 5) begin
        w = 6'($urandom_range(0, 15));
        cyc(w, $urandom(), 4'd0, 1'b1);
      end else if (r <= 8) begin
        case ($urandom_range(0, 3))
          0, 1:    w = 6'd3;
          2:       w = 6'd6;
          default: w = 6'($urandom_range(0, 15));
        endcase
        cyc(w, $urandom(), 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
      end else if (r == 9) begin
        cyc(6'd3, $urandom(), 4'd0, 1'($urandom_range(0, 1)));
      end else if (r <= 12) begin
        idle($urandom_range(1, 20));
      end else if (r <= 14) begin
        sendFrame(8'($urandom()), $urandom_range(0, 5) == 0);
      end else begin
        glitch();
      end
    end

    // Reset in the middle of the TX start bit
    idle(10 * CPB + 2);
    cyc(6'd4, 32'd0, 4'd0, 1'b1);
    cyc(6'd3, 32'h0000_005A, 4'b0010, 1'b0);
    idle(3);
    #2 rst = 1'b0;
    postLit(1'b1, 32'h1, "reset_serial_idle");
    @(negedge clk); #1 postLit(1'b0, 32'h0, "reset_rdata_clear");
    @(negedge clk); #1 rst = 1'b1;
    readExpect(6'd0, 32'h1, "reset_tx_ready_after");
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_uart_mmio.md
Name: io_uart_mmio

Overview:
Memory-mapped I/O slave for the MIPS150 pipeline: UART transmitter/receiver plus cycle and instruction counters.
- Takes X-stage ALU address, store data, the IO store mask and the load strobe.
- Returns registered read data one cycle later, aligned with DMEM's synchronous read, to feed the M-stage DMEM/IO writeback mux.
- Drives and samples the board serial pins.

Parameters:
CLK_FREQ, 50000000, core clock in Hz
BAUD_RATE, 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, 434 at defaults)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets immediately)
addr  in  32  byte address from X-stage ALU; block decodes addr[7:2] only (upper-nibble select done by memory map)
wdata  in  32  store data; only wdata[7:0] used
store_mask  in  4  IO byte write enables, big-endian; any nonzero value = write
load_en  in  1  X-stage IO load strobe
instr_valid  in  1  one instruction retired this cycle
rdata  out  32  registered read data, valid the cycle after load_en
serial_in  in  1  UART RX pin, asynchronous
serial_out  out  1  UART TX pin

Behaviour:
Register map (offset = addr[7:0]):
- 0x00 R: bit0 tx_ready.
- 0x04 R: bit0 rx_valid, bit1 frame_err, bit2 overrun; bits 1-2 are sticky and clear on this read.
- 0x08 R: rx byte zero-extended; the read pops it.
- 0x0C W: tx byte.
- 0x10 R: cycle counter.
- 0x14 R: instruction counter.
- 0x18 W: clears both counters.
- Unmapped reads return 0. Unmapped writes are ignored.

Read path:
- On the edge where load_en=1, rdata <= selected register; otherwise rdata holds.
- Pop / sticky-clear side effects occur on that same edge.

Reset values:
- rdata=0, serial_out=1, counters=0, rx_valid=0, frame_err=0, overrun=0.
- TX and RX FSMs in IDLE; tx_ready=1.

TX FSM (IDLE, START, DATA, STOP):
- A write to 0x0C in IDLE latches wdata[7:0] and enters START; the write is ignored when not IDLE.
- START drives 0, then 8 DATA bits LSB first, then STOP drives 1.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- tx_ready=1 only in IDLE. serial_out first goes low on the cycle after the write edge.

RX FSM (IDLE, START, DATA, STOP):
- serial_in passes through a 2-flop synchronizer.
- IDLE: a synchronized 0 enters START.
- START: at CLKS_PER_BIT/2 re-sample; if 1 it was a glitch, return to IDLE.
- DATA: sample each bit at mid-bit, LSB first.
- STOP: at mid-bit, if 1 deliver the byte; if 0 discard the byte and set frame_err. Return to IDLE.
- Delivery when rx_valid=1 already: new byte dropped, overrun set, stored byte kept.
- Delivery and pop on the same edge: pop returns the old byte, then the new byte is stored and rx_valid stays 1.

Counters:
- Cycle counter increments every cycle. Instruction counter increments when instr_valid=1.
- Both are 32-bit and wrap 0xFFFFFFFF->0.
- A clear on the same edge as an increment wins (result 0).
- Write and load on the same cycle are both honoured.

Reset mid-frame: serial_out returns to 1 immediately and any partial byte is lost.

Optional Feature:
UART_RX_FIFO_EN
- Defined: rx holding register replaced by 4-entry FIFO.
  - rx_valid = not empty; 0x08 pops the head.
  - Overrun only when a byte arrives with the FIFO full (byte dropped).
  - Push and pop on the same edge: both occur, count unchanged.
- Undefined: single holding register as above.

Test Plan:
- Reset, CLK_FREQ=1000, BAUD_RATE=100: write 0x0C wdata=0x000000A5 mask=0001 -> serial_out low 10 cycles, then bits 1,0,1,0,0,1,0,1 for 10 cycles each, then high; read 0x00 returns 0 during the frame and 1 after.
- Drive serial frame 0x3C on serial_in -> read 0x04 returns 0x1; read 0x08 returns 0x0000003C; next read 0x04 returns 0x0.
- Send two frames 0x11, 0x22 without popping -> 0x04 reads 0x5, then 0x08 reads 0x11. With UART_RX_FIFO_EN: 0x04 reads 0x1 and pops return 0x11 then 0x22.
- Frame 0x55 with stop bit 0 -> 0x04 reads 0x2, rx_valid 0; a second read returns 0x0.
- Write 0x18, run 100 cycles with instr_valid high 40 cycles -> 0x10 reads 100±1, 0x14 reads 40; force cycle counter to 0xFFFFFFFF -> next value 0.
- Write 0x0C, assert rst=0 mid-START -> serial_out=1 immediately, rdata=0, tx_ready=1 after release.
